// File: rtl/ahb_apb_req_arb.sv
// ----------------------------------------------------------------------------
// ahb_apb_req_arb
//   Two-requester round-robin arbiter that turns one granted request at a time
//   into a single AHB-lite transfer toward an AHB-to-APB bridge.
//   State flow per transfer: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//
// Ports
//   hclk, hreset        clock, asynchronous active-high reset
//   req, wr             per-requester request / direction (bit i = requester i)
//   addr, wdata, size   per-requester address, write data, HSIZE (slice i)
//   ack                 one-cycle completion pulse to the granted requester
//   rdata, err          read data / timeout-abort flag, valid while ack != 0
//   hsel_m .. hwdata_m  AHB-lite master outputs toward the bridge
//   hready_m, hrdata_m  bridge response
//
// Build option
//   AHB_APB_ARB_TIMEOUT_EN : adds a DATA-phase wait counter. After TIMEOUT
//   consecutive hready_m-low DATA cycles the transfer completes with err=1,
//   and no new grant is issued until the bridge shows hready_m=1 again.
//   Without the macro DATA waits indefinitely, err is 0 and TIMEOUT is unused.
// ----------------------------------------------------------------------------
module ahb_apb_req_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic [1:0]                req,
    input  logic [1:0]                wr,
    input  logic [2*ADDR_WIDTH-1:0]   addr,
    input  logic [2*DATA_WIDTH-1:0]   wdata,
    input  logic [5:0]                size,
    output logic [1:0]                ack,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      err,
    output logic                      hsel_m,
    output logic [1:0]                htrans_m,
    output logic                      hwrite_m,
    output logic [2:0]                hsize_m,
    output logic [ADDR_WIDTH-1:0]     haddr_m,
    output logic [DATA_WIDTH-1:0]     hwdata_m,
    input  logic                      hready_m,
    input  logic [DATA_WIDTH-1:0]     hrdata_m
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;   // requester owning the transfer
    logic                    prio_q,  prio_d;    // winner on a simultaneous request
    logic                    pick;
    logic                    wr_q,    wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]              size_q,  size_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    grant_ok;

`ifdef AHB_APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]        cnt_q,  cnt_d;
    logic                    hold_q, hold_d;     // set by a timeout, cleared by hready_m
    logic                    err_q,  err_d;

    // After an abort the bridge may still be busy; wait until it is ready.
    assign grant_ok = !hold_q || hready_m;
`else
    assign grant_ok = 1'b1;
`endif

    // Single request wins directly; a simultaneous request goes to prio_q.
    assign pick = (req == 2'b11) ? prio_q : req[1];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
`ifdef AHB_APB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        err_d   = err_q;
        if (state_q == IDLE && hready_m) begin
            hold_d = 1'b0;
        end
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00 && grant_ok) begin
                    grant_d = pick;
                    prio_d  = ~pick;
                    wr_d    = wr[pick];
                    addr_d  = addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                    size_d  = size[pick*3 +: 3];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (hready_m) begin
                    state_d = DATA;
`ifdef AHB_APB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            DATA: begin
                if (hready_m) begin
                    rdata_d = wr_q ? '0 : hrdata_m;
                    state_d = RESP;
`ifdef AHB_APB_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This wait cycle brings the count to TIMEOUT: abort.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
`ifdef AHB_APB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
`ifdef AHB_APB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef AHB_APB_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ack      = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rdata    = rdata_q;
    assign hsel_m   = (state_q == ADDR);
    assign htrans_m = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign hwrite_m = wr_q;
    assign hsize_m  = size_q;
    assign haddr_m  = addr_q;
    assign hwdata_m = wdata_q;

endmodule

// File: tb/tb_ahb_apb_req_arb.sv
module tb_ahb_apb_req_arb;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [5:0]  size;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        hsel_m;
    logic [1:0]  htrans_m;
    logic        hwrite_m;
    logic [2:0]  hsize_m;
    logic [31:0] haddr_m;
    logic [31:0] hwdata_m;
    logic        hready_m;
    logic [31:0] hrdata_m;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_apb_req_arb #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .req      (req),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .size     (size),
        .ack      (ack),
        .rdata    (rdata),
        .err      (err),
        .hsel_m   (hsel_m),
        .htrans_m (htrans_m),
        .hwrite_m (hwrite_m),
        .hsize_m  (hsize_m),
        .haddr_m  (haddr_m),
        .hwdata_m (hwdata_m),
        .hready_m (hready_m),
        .hrdata_m (hrdata_m)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        req = 2'b00; wr = 2'b00; addr = '0; wdata = '0; size = '0;
        hready_m = 1'b1; hrdata_m = '0;
        tick(); tick();
        checks++;
        if ({ack, err, rdata, hsel_m, htrans_m, hwrite_m, hsize_m, haddr_m, hwdata_m} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b err=%b rdata=%h hsel=%b htrans=%b hwrite=%b hsize=%h haddr=%h hwdata=%h, expected all zero",
                     ack, err, rdata, hsel_m, htrans_m, hwrite_m, hsize_m, haddr_m, hwdata_m);
        end
        hreset = 1'b0;
    endtask

    task automatic test_single_write();
        req = 2'b01; wr = 2'b01; addr[31:0] = 32'h40; wdata[31:0] = 32'hA5A5_0001; size[2:0] = 3'd2;
        hready_m = 1'b1;
        tick();
        checks++;
        if (htrans_m !== 2'b10 || hsel_m !== 1'b1) begin
            errors++; $display("FAIL wr_addr_phase: htrans=%b hsel=%b, expected 10 1", htrans_m, hsel_m);
        end
        checks++;
        if (haddr_m !== 32'h40 || hwrite_m !== 1'b1 || hsize_m !== 3'd2) begin
            errors++; $display("FAIL wr_addr_ctrl: haddr=%h hwrite=%b hsize=%0d, expected 40 1 2", haddr_m, hwrite_m, hsize_m);
        end
        checks++;
        if (ack !== 2'b00) begin
            errors++; $display("FAIL wr_ack_early1: ack=%b, expected 00", ack);
        end
        wdata[31:0] = 32'hDEAD_BEEF;  // must not disturb the latched data
        tick();
        checks++;
        if (htrans_m !== 2'b00 || hsel_m !== 1'b0) begin
            errors++; $display("FAIL wr_data_phase: htrans=%b hsel=%b, expected 00 0", htrans_m, hsel_m);
        end
        checks++;
        if (hwdata_m !== 32'hA5A5_0001) begin
            errors++; $display("FAIL wr_hwdata: hwdata=%h, expected a5a50001", hwdata_m);
        end
        checks++;
        if (ack !== 2'b00) begin
            errors++; $display("FAIL wr_ack_early2: ack=%b, expected 00", ack);
        end
        tick();
        checks++;
        if (ack !== 2'b01 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL wr_ack: ack=%b err=%b rdata=%h, expected 01 0 0", ack, err, rdata);
        end
        req = 2'b00;
        tick();
        checks++;
        if (ack !== 2'b00) begin
            errors++; $display("FAIL wr_ack_one_cycle: ack=%b, expected 00", ack);
        end
    endtask

    task automatic test_read_wait();
        req = 2'b10; wr = 2'b00; addr[63:32] = 32'h08; size[5:3] = 3'd2;
        hready_m = 1'b1; hrdata_m = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (htrans_m !== 2'b10 || haddr_m !== 32'h08 || hwrite_m !== 1'b0) begin
            errors++; $display("FAIL rd_addr_phase: htrans=%b haddr=%h hwrite=%b, expected 10 08 0", htrans_m, haddr_m, hwrite_m);
        end
        tick();
        hready_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ack !== 2'b00 || htrans_m !== 2'b00) begin
                errors++; $display("FAIL rd_wait_%0d: ack=%b htrans=%b, expected 00 00", i, ack, htrans_m);
            end
        end
        hready_m = 1'b1; hrdata_m = 32'h1234;
        tick();
        checks++;
        if (ack !== 2'b10 || rdata !== 32'h1234 || err !== 1'b0) begin
            errors++; $display("FAIL rd_ack: ack=%b rdata=%h err=%b, expected 10 1234 0", ack, rdata, err);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_addr_wait();
        req = 2'b01; wr = 2'b01; addr[31:0] = 32'h1C; wdata[31:0] = 32'h0000_0077;
        hready_m = 1'b0;
        tick();
        tick();
        checks++;
        if (htrans_m !== 2'b10 || hsel_m !== 1'b1 || haddr_m !== 32'h1C) begin
            errors++; $display("FAIL addr_hold: htrans=%b hsel=%b haddr=%h, expected 10 1 1c", htrans_m, hsel_m, haddr_m);
        end
        hready_m = 1'b1;
        tick();
        checks++;
        if (htrans_m !== 2'b00 || hwdata_m !== 32'h77) begin
            errors++; $display("FAIL addr_wait_data: htrans=%b hwdata=%h, expected 00 77", htrans_m, hwdata_m);
        end
        tick();
        checks++;
        if (ack !== 2'b01) begin
            errors++; $display("FAIL addr_wait_ack: ack=%b, expected 01", ack);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ack;
        logic [31:0] exp_addr;
        hreset = 1'b1;
        #1;
        req = 2'b11; wr = 2'b00; addr = {32'h200, 32'h100}; size = '0;
        hready_m = 1'b1; hrdata_m = 32'h55;
        tick();
        hreset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            exp_ack  = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (n % 2 == 0) ? 32'h100 : 32'h200;
            tick();
            checks++;
            if (htrans_m !== 2'b10 || haddr_m !== exp_addr) begin
                errors++; $display("FAIL rr_grant_%0d: htrans=%b haddr=%h, expected 10 %h", n, htrans_m, haddr_m, exp_addr);
            end
            tick();
            tick();
            checks++;
            if (ack !== exp_ack || rdata !== 32'h55) begin
                errors++; $display("FAIL rr_ack_%0d: ack=%b rdata=%h, expected %b 55", n, ack, rdata, exp_ack);
            end
            tick();
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 2'b01; wr = 2'b01; addr[31:0] = 32'h3C; wdata[31:0] = 32'hCAFE_0000; size[2:0] = 3'd1;
        hready_m = 1'b1;
        tick();
        tick();
        hready_m = 1'b0;
        req = 2'b00;
        #2;
        hreset = 1'b1;
        #1;
        checks++;
        if ({ack, err, rdata, hsel_m, htrans_m, hwrite_m, hsize_m, haddr_m, hwdata_m} !== '0) begin
            errors++;
            $display("FAIL midreset_async: ack=%b err=%b rdata=%h hsel=%b htrans=%b hwrite=%b hsize=%h haddr=%h hwdata=%h, expected all zero",
                     ack, err, rdata, hsel_m, htrans_m, hwrite_m, hsize_m, haddr_m, hwdata_m);
        end
        hready_m = 1'b1;
        tick();
        hreset = 1'b0;
        tick();
        checks++;
        if (ack !== 2'b00 || htrans_m !== 2'b00) begin
            errors++; $display("FAIL midreset_no_ack: ack=%b htrans=%b, expected 00 00", ack, htrans_m);
        end
        req = 2'b01; wr = 2'b00; addr[31:0] = 32'h44; hrdata_m = 32'h0BAD_F00D;
        tick();
        checks++;
        if (htrans_m !== 2'b10 || haddr_m !== 32'h44) begin
            errors++; $display("FAIL midreset_regrant: htrans=%b haddr=%h, expected 10 44", htrans_m, haddr_m);
        end
        tick();
        tick();
        checks++;
        if (ack !== 2'b01 || rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL midreset_ack: ack=%b rdata=%h, expected 01 0badf00d", ack, rdata);
        end
        req = 2'b00;
        tick();
    endtask

`ifdef AHB_APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req = 2'b01; wr = 2'b00; addr[31:0] = 32'h50; hready_m = 1'b1; hrdata_m = 32'h77;
        tick();
        tick();
        hready_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ack !== 2'b00) begin
                errors++; $display("FAIL to_wait_%0d: ack=%b, expected 00", i, ack);
            end
        end
        tick();
        checks++;
        if (ack !== 2'b01 || err !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL to_abort: ack=%b err=%b rdata=%h, expected 01 1 0", ack, err, rdata);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (hsel_m !== 1'b0 || htrans_m !== 2'b00) begin
                errors++; $display("FAIL to_holdoff_%0d: hsel=%b htrans=%b, expected 0 00", i, hsel_m, htrans_m);
            end
        end
        hready_m = 1'b1;
        tick();
        checks++;
        if (hsel_m !== 1'b1 || htrans_m !== 2'b10) begin
            errors++; $display("FAIL to_regrant: hsel=%b htrans=%b, expected 1 10", hsel_m, htrans_m);
        end
        tick();
        tick();
        checks++;
        if (ack !== 2'b01 || err !== 1'b0 || rdata !== 32'h77) begin
            errors++; $display("FAIL to_recover: ack=%b err=%b rdata=%h, expected 01 0 77", ack, err, rdata);
        end
        req = 2'b00;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_addr_wait();
        test_round_robin();
        test_reset_mid();
`ifdef AHB_APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
